// File: rtl/mac_pe_array_cell_if.sv
// Operand, forwarding and drain-chain signals of one systolic MAC processing element.
interface mac_pe_array_cell_if #(
  parameter int DW = 8,
  parameter int AW = 32
);
  logic          en;
  logic          in_valid;
  logic          clr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] weight_in;
  logic [DW-1:0] data_out;
  logic [DW-1:0] weight_out;
  logic          out_valid;
  logic [AW-1:0] acc;
  logic          ovf;
  logic          load;
  logic          shift;
  logic [AW-1:0] drain_in;
  logic          drain_vld_in;
  logic [AW-1:0] drain_out;
  logic          drain_vld;

  modport master (
    output en, in_valid, clr, data_in, weight_in, load, shift, drain_in, drain_vld_in,
    input  data_out, weight_out, out_valid, acc, ovf, drain_out, drain_vld
  );

  modport slave (
    input  en, in_valid, clr, data_in, weight_in, load, shift, drain_in, drain_vld_in,
    output data_out, weight_out, out_valid, acc, ovf, drain_out, drain_vld
  );
endinterface

// File: rtl/mac_pe_array_cell.sv
// Systolic-array MAC cell: forwards operands east/south, accumulates signed products
// with optional saturation, and owns one stage of a result drain chain. AW must be >= 2*DW.
module mac_pe_array_cell #(
  parameter int DW  = 8,
  parameter int AW  = 32,
  parameter int SAT = 1
) (
  input logic                clk,
  input logic                rst,
  mac_pe_array_cell_if.slave pe
);

  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] weight_q, weight_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] drain_q, drain_d;
  logic          drain_vld_q, drain_vld_d;

  logic signed [2*DW-1:0] data_sx, weight_sx, prod;
  logic signed [AW:0]     prod_ext, base_ext, sum;
  logic                   sum_ovf;
  logic [AW-1:0]          acc_mac;

  // One guard bit above AW makes overflow a simple disagreement of the top two bits.
  assign data_sx   = {{DW{pe.data_in[DW-1]}}, pe.data_in};
  assign weight_sx = {{DW{pe.weight_in[DW-1]}}, pe.weight_in};
  assign prod      = data_sx * weight_sx;
  assign prod_ext  = {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
  assign base_ext  = pe.clr ? '0 : {acc_q[AW-1], acc_q};
  assign sum       = base_ext + prod_ext;
  assign sum_ovf   = sum[AW] ^ sum[AW-1];

  always_comb begin
    acc_mac = sum[AW-1:0];
    if (sum_ovf && (SAT != 0)) begin
      acc_mac = sum[AW] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to "hold" first so no path leaves it unassigned (no latches).
    data_d      = data_q;
    weight_d    = weight_q;
    vld_d       = vld_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    drain_d     = drain_q;
    drain_vld_d = drain_vld_q;

    if (pe.en) begin
      data_d   = pe.data_in;
      weight_d = pe.weight_in;
      vld_d    = pe.in_valid;

      if (pe.in_valid) begin
        acc_d = acc_mac;
        ovf_d = (pe.clr ? 1'b0 : ovf_q) | sum_ovf;
      end else if (pe.clr) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end

      // Drain captures the pre-update accumulator, so a tile can close and reopen in one cycle.
      if (pe.load) begin
        drain_d     = acc_q;
        drain_vld_d = 1'b1;
      end else if (pe.shift) begin
        drain_d     = pe.drain_in;
        drain_vld_d = pe.drain_vld_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      data_q      <= '0;
      weight_q    <= '0;
      vld_q       <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      drain_q     <= '0;
      drain_vld_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      weight_q    <= weight_d;
      vld_q       <= vld_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      drain_q     <= drain_d;
      drain_vld_q <= drain_vld_d;
    end
  end

  assign pe.data_out   = data_q;
  assign pe.weight_out = weight_q;
  assign pe.out_valid  = vld_q;
  assign pe.acc        = acc_q;
  assign pe.ovf        = ovf_q;
  assign pe.drain_out  = drain_q;
  assign pe.drain_vld  = drain_vld_q;

endmodule

// File: tb/tb_mac_pe_array_cell.sv
// Scoreboard bench for mac_pe_array_cell: signed MAC, stall, saturate/wrap, back-to-back tiles, drain chain.
module tb_mac_pe_array_cell;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  mac_pe_array_cell_if #(.DW(8), .AW(32)) if32 ();
  mac_pe_array_cell_if #(.DW(8), .AW(16)) if16s ();
  mac_pe_array_cell_if #(.DW(8), .AW(16)) if16w ();
  mac_pe_array_cell_if #(.DW(8), .AW(32)) ifc0 ();
  mac_pe_array_cell_if #(.DW(8), .AW(32)) ifc1 ();
  mac_pe_array_cell_if #(.DW(8), .AW(32)) ifc2 ();

  mac_pe_array_cell #(.DW(8), .AW(32), .SAT(1)) u_mac32 (.clk(clk), .rst(rst), .pe(if32));
  mac_pe_array_cell #(.DW(8), .AW(16), .SAT(1)) u_sat16 (.clk(clk), .rst(rst), .pe(if16s));
  mac_pe_array_cell #(.DW(8), .AW(16), .SAT(0)) u_wrp16 (.clk(clk), .rst(rst), .pe(if16w));
  mac_pe_array_cell #(.DW(8), .AW(32), .SAT(1)) u_cell0 (.clk(clk), .rst(rst), .pe(ifc0));
  mac_pe_array_cell #(.DW(8), .AW(32), .SAT(1)) u_cell1 (.clk(clk), .rst(rst), .pe(ifc1));
  mac_pe_array_cell #(.DW(8), .AW(32), .SAT(1)) u_cell2 (.clk(clk), .rst(rst), .pe(ifc2));

  assign ifc1.drain_in     = ifc0.drain_out;
  assign ifc1.drain_vld_in = ifc0.drain_vld;
  assign ifc2.drain_in     = ifc1.drain_out;
  assign ifc2.drain_vld_in = ifc1.drain_vld;

  typedef struct packed {
    logic [31:0] acc;
    logic        ovf;
    logic [7:0]  dout;
    logic [7:0]  wout;
    logic        vld;
    logic [31:0] drain;
    logic        dvld;
  } obs32_t;

  typedef struct packed {
    logic [15:0] sacc;
    logic        sovf;
    logic [15:0] wacc;
    logic        wovf;
  } obs16_t;

  typedef struct packed {
    logic [31:0] acc0;
    logic [31:0] acc1;
    logic [31:0] acc2;
    logic [31:0] drain2;
    logic        v0;
    logic        v1;
    logic        v2;
  } obsc_t;

  typedef struct { string name; obs32_t v; } sb32_t;
  typedef struct { string name; obs16_t v; } sb16_t;
  typedef struct { string name; obsc_t  v; } sbc_t;

  sb32_t q32[$];
  sb16_t q16[$];
  sbc_t  qc[$];

  function automatic obs32_t obs32_now();
    return {if32.acc, if32.ovf, if32.data_out, if32.weight_out, if32.out_valid,
            if32.drain_out, if32.drain_vld};
  endfunction

  function automatic obs16_t obs16_now();
    return {if16s.acc, if16s.ovf, if16w.acc, if16w.ovf};
  endfunction

  function automatic obsc_t obsc_now();
    return {ifc0.acc, ifc1.acc, ifc2.acc, ifc2.drain_out,
            ifc0.drain_vld, ifc1.drain_vld, ifc2.drain_vld};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic en, input logic vld, input logic clr,
                         input logic [7:0] d, input logic [7:0] w,
                         input logic load, input logic shift,
                         input logic [31:0] din, input logic dvin);
    if32.en = en; if32.in_valid = vld; if32.clr = clr;
    if32.data_in = d; if32.weight_in = w;
    if32.load = load; if32.shift = shift;
    if32.drain_in = din; if32.drain_vld_in = dvin;
  endtask

  task automatic drive16(input logic en, input logic vld, input logic clr,
                         input logic [7:0] d, input logic [7:0] w);
    if16s.en = en; if16s.in_valid = vld; if16s.clr = clr;
    if16s.data_in = d; if16s.weight_in = w;
    if16s.load = 1'b0; if16s.shift = 1'b0; if16s.drain_in = '0; if16s.drain_vld_in = 1'b0;
    if16w.en = en; if16w.in_valid = vld; if16w.clr = clr;
    if16w.data_in = d; if16w.weight_in = w;
    if16w.load = 1'b0; if16w.shift = 1'b0; if16w.drain_in = '0; if16w.drain_vld_in = 1'b0;
  endtask

  task automatic drive_chain(input logic en, input logic vld, input logic clr,
                             input logic load, input logic shift,
                             input logic [7:0] d0, input logic [7:0] w0,
                             input logic [7:0] d1, input logic [7:0] w1,
                             input logic [7:0] d2, input logic [7:0] w2);
    ifc0.en = en; ifc0.in_valid = vld; ifc0.clr = clr; ifc0.load = load; ifc0.shift = shift;
    ifc1.en = en; ifc1.in_valid = vld; ifc1.clr = clr; ifc1.load = load; ifc1.shift = shift;
    ifc2.en = en; ifc2.in_valid = vld; ifc2.clr = clr; ifc2.load = load; ifc2.shift = shift;
    ifc0.data_in = d0; ifc0.weight_in = w0;
    ifc1.data_in = d1; ifc1.weight_in = w1;
    ifc2.data_in = d2; ifc2.weight_in = w2;
    ifc0.drain_in = '0; ifc0.drain_vld_in = 1'b0;
  endtask

  task automatic test_reset();
    sb32_t e32; sb16_t e16; sbc_t ec;
    obs32_t g32; obs16_t g16; obsc_t gc;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive32(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom), $urandom, 1'($urandom));
      drive16(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      drive_chain(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom));
      step();
    end
    for (int i = 0; i < 2; i++) begin
      q32.push_back(sb32_t'{$sformatf("reset32_%0d", i), obs32_t'('0)});
      q16.push_back(sb16_t'{$sformatf("reset16_%0d", i), obs16_t'('0)});
      qc.push_back(sbc_t'{$sformatf("reset_chain_%0d", i), obsc_t'('0)});
      if (i == 1) begin
        rst = 1'b0;
        drive32(1'b0, 1'b1, 1'b0, 8'h55, 8'h66, 1'b1, 1'b0, 32'h0, 1'b0);
        drive16(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_chain(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        step();
      end
      e32 = q32.pop_front(); g32 = obs32_now(); checks++;
      if (g32 !== e32.v) begin
        errors++;
        $display("FAIL %s: got %h want %h", e32.name, g32, e32.v);
      end
      e16 = q16.pop_front(); g16 = obs16_now(); checks++;
      if (g16 !== e16.v) begin
        errors++;
        $display("FAIL %s: got %h want %h", e16.name, g16, e16.v);
      end
      ec = qc.pop_front(); gc = obsc_now(); checks++;
      if (gc !== ec.v) begin
        errors++;
        $display("FAIL %s: got %h want %h", ec.name, gc, ec.v);
      end
    end
  endtask

  task automatic test_signed_mac();
    sb32_t e; obs32_t g;
    logic       vld_t[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       clr_t[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] d_t[4]   = '{8'hFD, 8'h7F, 8'h80, 8'h11};
    logic [7:0] w_t[4]   = '{8'h05, 8'h7F, 8'h80, 8'h22};
    int         acc_t[4] = '{-15, 16114, 32498, 32498};
    for (int i = 0; i < 4; i++) begin
      drive32(1'b1, vld_t[i], clr_t[i], d_t[i], w_t[i], 1'b0, 1'b0, 32'h0, 1'b0);
      q32.push_back(sb32_t'{$sformatf("mac_%0d", i),
        obs32_t'{acc: 32'(acc_t[i]), ovf: 1'b0, dout: d_t[i], wout: w_t[i],
                 vld: vld_t[i], drain: 32'h0, dvld: 1'b0}});
      step();
      e = q32.pop_front(); g = obs32_now(); checks++;
      if (g !== e.v) begin
        errors++;
        $display("FAIL %s: got acc=%0d fwd=%h/%h/%b want acc=%0d fwd=%h/%h/%b",
                 e.name, $signed(g.acc), g.dout, g.wout, g.vld,
                 $signed(e.v.acc), e.v.dout, e.v.wout, e.v.vld);
      end
    end
  endtask

  task automatic test_stall();
    sb32_t e; obs32_t g; obs32_t hold;
    hold = '{acc: 32'd32504, ovf: 1'b0, dout: 8'h02, wout: 8'h03, vld: 1'b1,
             drain: 32'h0, dvld: 1'b0};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        drive32(1'b1, 1'b1, 1'b0, 8'h02, 8'h03, 1'b0, 1'b0, 32'h0, 1'b0);
        q32.push_back(sb32_t'{"stall_pre", hold});
      end else if (i < 4) begin
        drive32(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                1'b1, 1'($urandom), $urandom, 1'b1);
        q32.push_back(sb32_t'{$sformatf("stall_frozen_%0d", i), hold});
      end else begin
        drive32(1'b1, 1'b1, 1'b0, 8'h01, 8'hFF, 1'b0, 1'b0, 32'h0, 1'b0);
        q32.push_back(sb32_t'{"stall_resume",
          obs32_t'{acc: 32'd32503, ovf: 1'b0, dout: 8'h01, wout: 8'hFF, vld: 1'b1,
                   drain: 32'h0, dvld: 1'b0}});
      end
      step();
      e = q32.pop_front(); g = obs32_now(); checks++;
      if (g !== e.v) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, g, e.v);
      end
    end
  endtask

  task automatic test_saturation();
    sb16_t e; obs16_t g;
    logic       vld_t[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       clr_t[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] d_t[9]    = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h80, 8'h80, 8'h80, 8'h01};
    logic [7:0] w_t[9]    = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h01};
    int         sacc_t[9] = '{16129, 32258, 32767, 32767, 0, -16256, -32512, -32768, 1};
    int         wacc_t[9] = '{16129, 32258, -17149, -1020, 0, -16256, -32512, 16768, 1};
    logic       ovf_t[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive16(1'b1, vld_t[i], clr_t[i], d_t[i], w_t[i]);
      q16.push_back(sb16_t'{$sformatf("sat_%0d", i),
        obs16_t'{sacc: 16'(sacc_t[i]), sovf: ovf_t[i], wacc: 16'(wacc_t[i]), wovf: ovf_t[i]}});
      step();
      e = q16.pop_front(); g = obs16_now(); checks++;
      if (g !== e.v) begin
        errors++;
        $display("FAIL %s: got sat=%0d/%b wrap=%0d/%b want sat=%0d/%b wrap=%0d/%b",
                 e.name, $signed(g.sacc), g.sovf, $signed(g.wacc), g.wovf,
                 $signed(e.v.sacc), e.v.sovf, $signed(e.v.wacc), e.v.wovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    sb32_t e; obs32_t g;
    logic        vld_t[5]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        clr_t[5]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0]  d_t[5]     = '{8'h0A, 8'h02, 8'h00, 8'h01, 8'h00};
    logic [7:0]  w_t[5]     = '{8'h0A, 8'h03, 8'h00, 8'h01, 8'h00};
    logic        load_t[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        shift_t[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        dvin_t[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] acc_t[5]   = '{32'd100, 32'd6, 32'd6, 32'd7, 32'd7};
    logic [31:0] dr_t[5]    = '{32'd0, 32'd100, 32'd100, 32'd6, 32'hDEADBEEF};
    logic        dv_t[5]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive32(1'b1, vld_t[i], clr_t[i], d_t[i], w_t[i], load_t[i], shift_t[i],
              32'hDEADBEEF, dvin_t[i]);
      q32.push_back(sb32_t'{$sformatf("b2b_%0d", i),
        obs32_t'{acc: acc_t[i], ovf: 1'b0, dout: d_t[i], wout: w_t[i], vld: vld_t[i],
                 drain: dr_t[i], dvld: dv_t[i]}});
      step();
      e = q32.pop_front(); g = obs32_now(); checks++;
      if (g !== e.v) begin
        errors++;
        $display("FAIL %s: got acc=%0d drain=%h/%b want acc=%0d drain=%h/%b (full got %h want %h)",
                 e.name, $signed(g.acc), g.drain, g.dvld, $signed(e.v.acc), e.v.drain,
                 e.v.dvld, g, e.v);
      end
    end
  endtask

  task automatic test_drain_chain();
    sbc_t e; obsc_t g; sb32_t e32; obs32_t g32;
    logic        load_t[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        shift_t[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] dr_t[7]    = '{32'd0, 32'd30, 32'd20, 32'd10, 32'd0, 32'd30, 32'd20};
    logic [2:0]  v_t[7]     = '{3'b000, 3'b111, 3'b011, 3'b001, 3'b000, 3'b111, 3'b011};
    drive32(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        drive_chain(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd5, 8'd4, 8'd5, 8'd5, 8'd6);
      end else if (i < 7) begin
        drive_chain(1'b1, 1'b0, 1'b0, load_t[i], shift_t[i],
                    8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      end else begin
        rst = 1'b1;
        drive_chain(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      end
      if (i < 7) begin
        qc.push_back(sbc_t'{$sformatf("chain_%0d", i),
          obsc_t'{acc0: 32'd10, acc1: 32'd20, acc2: 32'd30, drain2: dr_t[i],
                  v0: v_t[i][2], v1: v_t[i][1], v2: v_t[i][0]}});
      end else begin
        qc.push_back(sbc_t'{"chain_reset_mid_shift", obsc_t'('0)});
      end
      step();
      e = qc.pop_front(); g = obsc_now(); checks++;
      if (g !== e.v) begin
        errors++;
        $display("FAIL %s: got drain2=%0d vld=%b%b%b acc=%0d/%0d/%0d want drain2=%0d vld=%b%b%b acc=%0d/%0d/%0d",
                 e.name, g.drain2, g.v0, g.v1, g.v2, g.acc0, g.acc1, g.acc2,
                 e.v.drain2, e.v.v0, e.v.v1, e.v.v2, e.v.acc0, e.v.acc1, e.v.acc2);
      end
    end
    // First operation after reset, without clr, starts from an empty accumulator.
    rst = 1'b0;
    drive32(1'b1, 1'b1, 1'b0, 8'h03, 8'h04, 1'b0, 1'b0, 32'h0, 1'b0);
    q32.push_back(sb32_t'{"post_reset_first_mac",
      obs32_t'{acc: 32'd12, ovf: 1'b0, dout: 8'h03, wout: 8'h04, vld: 1'b1,
               drain: 32'h0, dvld: 1'b0}});
    step();
    e32 = q32.pop_front(); g32 = obs32_now(); checks++;
    if (g32 !== e32.v) begin
      errors++;
      $display("FAIL %s: got acc=%0d want acc=%0d (full got %h want %h)",
               e32.name, $signed(g32.acc), $signed(e32.v.acc), g32, e32.v);
    end
  endtask

  initial begin
    drive32(1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive16(1'b0, 1'b0, 1'b0, 8'h0, 8'h0);
    drive_chain(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    test_reset();
    test_signed_mac();
    test_stall();
    test_saturation();
    test_back_to_back();
    test_drain_chain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
